mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer and two-way arbiter for the unified 128-word instruction/data memory array of the multi-cycle MIPS datapath. It accepts independent request/acknowledge transactions from the instruction-fetch unit and the load/store unit and serialises them onto the single memory port. It drives the memory's address, write-data, 2-bit operation code and instruction/data region select from registers, so memory control is never glitchy. It captures read data and returns it with a one-cycle acknowledge pulse.

## Interface
- N, default 32, data and address width
- ADDR_W, default 6, word-index bits per region; higher address bits must be zero
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- i_req  in  1  instruction-fetch request (read only), held until i_ack
- i_addr  in  N  instruction word index
- i_ack  out  1  one-cycle completion pulse
- i_rdata  out  N  fetched word, valid when i_ack=1
- i_err  out  1  address out of range, valid when i_ack=1
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  N  data word index
- d_wdata  in  N  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  N  load data, valid when d_ack=1 and d_we was 0
- d_err  out  1  address out of range, valid when d_ack=1
- mem_addr  out  N  memory address, registered
- mem_wdata  out  N  memory write data, registered
- mem_op  out  2  memory operation: 2'b01 = read, 2'b10 = write, 2'b00 = idle; 2'b11 is never driven
- mem_inst  out  1  region select: 1 = instruction port, 0 = data port
- mem_rdata  in  N  combinational read data from memory

## Operation
- FSM has three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Request present: select a winner and latch its address, write data, operation and port ID.
  - Address in range: go to ACCESS.
  - Address out of range (addr[N-1:ADDR_W] != 0): go to RESP with the error flag set. No memory operation is issued.
- ACCESS:
  - Drive mem_op, mem_addr, mem_wdata and mem_inst from the latched values.
  - For a read, capture mem_rdata into the response register.
  - Go to RESP.
- RESP:
  - Pulse the winner's ack and its err.
  - rdata holds the captured word, or 0 for writes and errors.
  - mem_op is 00.
  - Go to IDLE.
- Request and acknowledge rules:
  - A request must be held with stable payload until its ack.
  - The requester must deassert req in the cycle after ack, or present a new transaction there.
  - A request that stays high after ack is a new transaction.
- Loser of an arbitration keeps its req high and is served in the next IDLE.
- Instruction port never writes. mem_op is 01 for every instruction access.

## Timing
- Reset values:
  - i_ack, d_ack, i_err, d_err are 0.
  - i_rdata, d_rdata, mem_addr, mem_wdata are 0.
  - mem_op is 2'b00; mem_inst is 0.
  - Round-robin pointer points to the instruction port.
- Latency for a normal access: request sampled in IDLE at cycle T, mem_op active in cycle T+1, ack in cycle T+2.
- Latency for an error: ack+err at T+1.
- Maximum throughput is one access per 3 cycles.
- mem_op is non-zero in ACCESS only, for exactly one cycle. Address and data are stable for that whole cycle.
- rst asserted in any state, including mid-ACCESS:
  - Next state is IDLE; all outputs return to their reset values.
  - No ack is issued for the aborted transaction.
  - A write aborted in ACCESS may already have landed in memory.
- Both requests in the same IDLE cycle: resolved as described under Configuration.

## Configuration
- MEM_ARB_RR_EN defined:
  - Two-way round-robin arbitration. A 1-bit pointer records the last granted port; on a tie the other port wins.
  - The pointer updates only when a transaction is granted, including error transactions.
- MEM_ARB_RR_EN undefined:
  - Fixed priority: the data port always wins ties. The instruction port may starve.
  - The pointer register is not instantiated.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - constants OP_IDLE = 2'b00, OP_READ = 2'b01, OP_WRITE = 2'b10
  - port ID constants PORT_I = 1'b1, PORT_D = 1'b0
- Sub-module rr_arb2: 2-request arbiter producing a one-hot grant. It contains the pointer when MEM_ARB_RR_EN is defined.

## Test plan
- Data store then load: d_req, d_we=1, d_addr=5, d_wdata=0xDEADBEEF.
  - Store: mem_op=10, mem_inst=0, mem_addr=5 for one cycle; d_ack 2 cycles after the request is sampled.
  - Load from addr 5: d_rdata=0xDEADBEEF with d_ack.
- Instruction fetch from i_addr=3, with the instruction region preloaded at word 3 with 0x20080001: mem_op=01, mem_inst=1; i_ack with i_rdata=0x20080001 at T+2.
- Simultaneous i_req and d_req held high for 4 transactions:
  - MEM_ARB_RR_EN defined: grants alternate D, I, D, I.
  - MEM_ARB_RR_EN undefined: D is granted repeatedly while d_req stays high; I is granted only once d_req drops.
- d_addr=0x40, out of range: d_ack with d_err=1 at T+1; mem_op stays 00 throughout; d_rdata=0.
- rst asserted during ACCESS of a load: next cycle the FSM is in IDLE, mem_op=00 and no d_ack. After rst drops, a still-held d_req completes normally.
- Back-to-back: d_req stays high after d_ack with a new address. The new transaction is sampled in the following IDLE, with no lost or duplicated ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    localparam logic PORT_I = 1'b1;
    localparam logic PORT_D = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter with a one-hot grant, bit PORT_I = instruction, bit PORT_D = data.
// Round-robin when MEM_ARB_RR_EN is defined, otherwise fixed data-port priority.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_inst,
    input  logic       i_req_data,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

`ifdef MEM_ARB_RR_EN
    logic r_last;

    // r_last remembers the most recently granted port; a tie goes to the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= PORT_I;
        end else if (i_update && (i_req_inst || i_req_data)) begin
            r_last <= o_gnt[PORT_I] ? PORT_I : PORT_D;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        o_gnt = '0;
        if (i_req_inst && i_req_data) begin
            if (r_last == PORT_I) o_gnt[PORT_D] = 1'b1;
            else                  o_gnt[PORT_I] = 1'b1;
        end else begin
            o_gnt[PORT_I] = i_req_inst;
            o_gnt[PORT_D] = i_req_data;
        end
    end
`else
    logic w_unused;
    assign w_unused = clk ^ rst ^ i_update;

    always_comb begin
        o_gnt = '0;
        if (i_req_data) o_gnt[PORT_D] = 1'b1;
        else            o_gnt[PORT_I] = i_req_inst;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store requests onto one registered memory port.
// Optional round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic [N-1:0] i_addr,
    output logic         i_ack,
    output logic [N-1:0] i_rdata,
    output logic         i_err,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [N-1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    output logic         d_ack,
    output logic [N-1:0] d_rdata,
    output logic         d_err,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic [1:0]   mem_op,
    output logic         mem_inst,
    input  logic [N-1:0] mem_rdata
);

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   w_gnt;
    logic         w_any;
    logic         w_sel_inst;
    logic [N-1:0] w_addr;
    logic         w_oor;

    logic         r_port;
    logic         r_i_ack;
    logic         r_i_err;
    logic [N-1:0] r_i_rdata;
    logic         r_d_ack;
    logic         r_d_err;
    logic [N-1:0] r_d_rdata;
    logic [N-1:0] r_mem_addr;
    logic [N-1:0] r_mem_wdata;
    logic [1:0]   r_mem_op;
    logic         r_mem_inst;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req_inst (i_req),
        .i_req_data (d_req),
        .i_update   (r_state == IDLE),
        .o_gnt      (w_gnt)
    );

    assign w_any      = i_req | d_req;
    assign w_sel_inst = w_gnt[PORT_I];
    assign w_addr     = w_sel_inst ? i_addr : d_addr;
    assign w_oor      = |w_addr[N-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = w_oor ? RESP : ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Memory controls are loaded on entry to ACCESS and cleared on leaving it,
    // so mem_op is non-zero for exactly the ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port      <= PORT_D;
            r_i_ack     <= 1'b0;
            r_i_err     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_ack     <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_op    <= OP_IDLE;
            r_mem_inst  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_port <= w_sel_inst;
                        if (w_oor) begin
                            if (w_sel_inst) begin
                                r_i_ack <= 1'b1;
                                r_i_err <= 1'b1;
                            end else begin
                                r_d_ack <= 1'b1;
                                r_d_err <= 1'b1;
                            end
                        end else begin
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_sel_inst ? '0 : d_wdata;
                            r_mem_op    <= (!w_sel_inst && d_we) ? OP_WRITE : OP_READ;
                            r_mem_inst  <= w_sel_inst;
                        end
                    end
                end
                ACCESS: begin
                    r_mem_op <= OP_IDLE;
                    if (r_port == PORT_I) begin
                        r_i_ack   <= 1'b1;
                        r_i_rdata <= mem_rdata;
                    end else begin
                        r_d_ack   <= 1'b1;
                        r_d_rdata <= (r_mem_op == OP_READ) ? mem_rdata : '0;
                    end
                end
                RESP: begin
                    r_i_ack   <= 1'b0;
                    r_i_err   <= 1'b0;
                    r_i_rdata <= '0;
                    r_d_ack   <= 1'b0;
                    r_d_err   <= 1'b0;
                    r_d_rdata <= '0;
                end
                default: r_mem_op <= OP_IDLE;
            endcase
        end
    end

    assign i_ack     = r_i_ack;
    assign i_err     = r_i_err;
    assign i_rdata   = r_i_rdata;
    assign d_ack     = r_d_ack;
    assign d_err     = r_d_err;
    assign d_rdata   = r_d_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_op    = r_mem_op;
    assign mem_inst  = r_mem_inst;

endmodule
